// File: rtl/led_pkg.sv
// LED PWM controller shared types and defaults.
// Mode encoding matches the 2-bit mode register field.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } led_mode_e;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_PWM_BITS      = 8;
  localparam int DEF_PRESC_BITS    = 8;
  localparam int DEF_BLINK_PERIODS = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: shadow/active registers,
// breathe ramp and registered PWM compare.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_hit,
  input  logic                wr_sel,
  input  logic [PWM_BITS-1:0] wr_data,
  input  logic                wrap_tick,
  input  logic                blink_on,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] sh_duty;
  logic [PWM_BITS-1:0] act_duty;
  logic [PWM_BITS-1:0] nx_duty;
  logic [PWM_BITS-1:0] ramp;
  logic [PWM_BITS-1:0] ramp_nx;
  logic [PWM_BITS-1:0] level;
  led_mode_e           sh_mode;
  led_mode_e           act_mode;
  led_mode_e           nx_mode;
  logic                ramp_up;
  logic                ramp_up_nx;
  logic                up;
  logic                below;
  logic                at_zero;

  always_comb begin
    nx_duty = sh_duty;
    nx_mode = sh_mode;
    if (wr_hit && !wr_sel) nx_duty = wr_data;
    if (wr_hit && wr_sel)  nx_mode = led_mode_e'(wr_data[1:0]);
  end

  // a duty lowered under the ramp turns it downward
  assign up      = ramp_up && !(nx_duty < ramp);
  assign below   = ramp < nx_duty;
  assign at_zero = (ramp == '0);

  always_comb begin
    ramp_nx    = ramp;
    ramp_up_nx = up;
    unique case (1'b1)
      up && below:
        ramp_nx = ramp + ONE;
      up && !below: begin
        ramp_up_nx = 1'b0;
        ramp_nx    = at_zero ? ramp : ramp - ONE;
      end
      !up && !at_zero:
        ramp_nx = ramp - ONE;
      default: begin
        ramp_up_nx = 1'b1;
        if (nx_duty != '0) ramp_nx = ramp + ONE;
      end
    endcase
  end

  always_comb begin
    level = '0;
    unique case (act_mode)
      MODE_OFF:     level = '0;
      MODE_STATIC:  level = act_duty;
      MODE_BLINK:   level = blink_on ? act_duty : '0;
      MODE_BREATHE: level = ramp;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_duty  <= '0;
      sh_mode  <= MODE_OFF;
      act_duty <= '0;
      act_mode <= MODE_OFF;
      ramp     <= '0;
      ramp_up  <= 1'b1;
      led      <= 1'b0;
    end else begin
      sh_duty <= nx_duty;
      sh_mode <= nx_mode;
      if (wrap_tick) begin
        act_duty <= nx_duty;
        act_mode <= nx_mode;
        // leaving breathe parks the ramp so re-entry starts at 0, up
        if (nx_mode == MODE_BREATHE) begin
          ramp    <= ramp_nx;
          ramp_up <= ramp_up_nx;
        end else begin
          ramp    <= '0;
          ramp_up <= 1'b1;
        end
      end
      led <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_pwm_controller.sv
// Multi-channel LED PWM controller: prescaler,
// shared PWM counter and blink phase, per-channel slices.
module led_pwm_controller
  import led_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int PWM_BITS      = DEF_PWM_BITS,
  parameter int PRESC_BITS    = DEF_PRESC_BITS,
  parameter int BLINK_PERIODS = DEF_BLINK_PERIODS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [idx_width(NUM_CH)-1:0] wr_ch,
  input  logic                         wr_sel,
  input  logic [PWM_BITS-1:0]          wr_data,
  input  logic [PRESC_BITS-1:0]        prescale,
  output logic [NUM_CH-1:0]            led_out,
  output logic                         period_start
);

  localparam int CH_W = idx_width(NUM_CH);
  localparam int BL_W = idx_width(BLINK_PERIODS);
  localparam logic [BL_W-1:0] BL_LAST =
    BL_W'(BLINK_PERIODS - 1);

  logic [PRESC_BITS-1:0] presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BL_W-1:0]       blink_cnt;
  logic                  blink_on;
  logic                  tick;
  logic                  wrap_tick;

  // >= lets a shrinking prescale restart at once
  assign tick      = (presc_cnt >= prescale);
  assign wrap_tick = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
      blink_cnt    <= '0;
      blink_on     <= 1'b1;
    end else begin
      presc_cnt    <= tick ? '0 : presc_cnt + PRESC_BITS'(1);
      period_start <= wrap_tick;
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wrap_tick) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BL_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_hit   (wr_en && (wr_ch == CH_W'(i))),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .wrap_tick(wrap_tick),
      .blink_on (blink_on),
      .pwm_cnt  (pwm_cnt),
      .led      (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_controller.sv
// Bench for led_pwm_controller: per-period high
// counts scored against queued expectations.
`timescale 1ns/1ps
module tb_led_pwm_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic       wr_sel;
  logic [7:0] wr_data;
  logic [7:0] prescale;
  logic [3:0] led_out;
  logic       period_start;

  always #5 clk = ~clk;

  led_pwm_controller dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .prescale    (prescale),
    .led_out     (led_out),
    .period_start(period_start)
  );

  typedef struct packed {
    int               idx;
    int               len;
    logic [3:0][15:0] hi;
  } exp_t;

  typedef struct packed {
    logic [7:0]       presc;
    logic [3:0][1:0]  mode;
    logic [3:0][7:0]  duty;
    logic [3:0][15:0] hi;
    logic [15:0]      len;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[4];
  int   brl[12];
  int   checks = 0;
  int   failures = 0;
  int   pidx = 0;
  int   win_len = 0;
  int   hi_cnt[4];
  int   a, p, n, q;

  task automatic check(input string name,
                       input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic logic [3:0][15:0] hi4(
    input int h0, h1, h2, h3);
    logic [3:0][15:0] h;
    h[0] = 16'(h0);
    h[1] = 16'(h1);
    h[2] = 16'(h2);
    h[3] = 16'(h3);
    return h;
  endfunction

  function automatic vec_t mkvec(
    input int pr, m0, m1, m2, m3,
    d0, d1, d2, d3, h0, h1, h2, h3, len);
    vec_t v;
    v.presc   = 8'(pr);
    v.mode[0] = 2'(m0);
    v.mode[1] = 2'(m1);
    v.mode[2] = 2'(m2);
    v.mode[3] = 2'(m3);
    v.duty[0] = 8'(d0);
    v.duty[1] = 8'(d1);
    v.duty[2] = 8'(d2);
    v.duty[3] = 8'(d3);
    v.hi      = hi4(h0, h1, h2, h3);
    v.len     = 16'(len);
    return v;
  endfunction

  task automatic push_exp(input int idx,
                          input logic [3:0][15:0] hi,
                          input int len);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.hi  = hi;
    sbq.push_back(e);
  endtask

  task automatic score(input int w);
    exp_t e;
    while (sbq.size() > 0 && sbq[0].idx < w) begin
      checks++;
      failures++;
      $display("FAIL win%0d_missed got=none want=scored",
               sbq[0].idx);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].idx == w) begin
      e = sbq.pop_front();
      check($sformatf("win%0d_len", w), win_len, e.len);
      for (int c = 0; c < 4; c++)
        check($sformatf("win%0d_ch%0d_high", w, c),
              hi_cnt[c], int'(e.hi[c]));
    end
  endtask

  task automatic monitor();
    bit started = 1'b0;
    forever begin
      @(negedge clk);
      if (period_start) begin
        if (started) score(pidx);
        started = 1'b1;
        pidx++;
        win_len = 0;
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
      end
      win_len++;
      for (int c = 0; c < 4; c++)
        hi_cnt[c] += int'(led_out[c]);
    end
  endtask

  task automatic wr(input int ch, input int sel,
                    input int d);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_sel  = (sel != 0);
    wr_data = 8'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idx(input int target,
                          input int budget);
    int k = 0;
    while (pidx < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (pidx < target) begin
      checks++;
      failures++;
      $display("FAIL wait_period got=%0d want=%0d",
               pidx, target);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sbq.size() > 0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain got=%0d want=0 pending",
               sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_sel   = 1'b0;
    wr_data  = '0;
    prescale = '0;
    brl = '{1, 2, 3, 2, 1, 0, 1, 2, 1, 0, 1, 0};
    vt[0] = mkvec(0, 1, 1, 0, 1, 64, 128, 200, 0,
                  64, 128, 0, 0, 256);
    vt[1] = mkvec(3, 1, 1, 1, 0, 255, 128, 1, 9,
                  1020, 512, 4, 0, 1024);
    vt[2] = mkvec(0, 1, 1, 1, 1, 255, 255, 255, 255,
                  255, 255, 255, 255, 256);
    vt[3] = mkvec(1, 1, 0, 1, 1, 10, 255, 254, 100,
                  20, 0, 508, 200, 512);
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_led", int'(led_out), 0);
    check("rst_ps", int'(period_start), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      int cur;
      wait_idx(pidx + 1, 2100);
      @(posedge clk); #1;
      prescale = vt[v].presc;
      for (int c = 0; c < 4; c++) begin
        wr(c, 1, int'(vt[v].mode[c]));
        wr(c, 0, int'(vt[v].duty[c]));
      end
      cur = pidx;
      for (int k = 1; k <= 2; k++)
        push_exp(cur + k, vt[v].hi, int'(vt[v].len));
      wait_drain(3 * 1024 + 200);
    end

    // mid-period write, then a write in the wrap cycle
    wait_idx(pidx + 1, 1200);
    @(posedge clk); #1;
    prescale = 8'd0;
    wr(0, 1, 1); wr(0, 0, 20);
    wr(1, 1, 0);
    wr(2, 1, 1); wr(2, 0, 100);
    wr(3, 1, 0);
    a = pidx + 1;
    push_exp(a, hi4(20, 0, 100, 0), 256);
    wait_idx(a, 600);
    repeat (128) @(posedge clk);
    #1;
    wr(2, 0, 200);
    push_exp(a + 1, hi4(20, 0, 200, 0), 256);
    wait_idx(a + 1, 600);
    repeat (255) @(posedge clk);
    #1;
    wr(0, 0, 77);
    push_exp(a + 2, hi4(77, 0, 200, 0), 256);
    wait_drain(1200);

    // breathe ramp, then duty lowered under the level
    @(posedge clk); #1;
    wr(0, 1, 3); wr(0, 0, 3);
    wr(2, 1, 0);
    a = pidx + 1;
    for (int k = 0; k < 8; k++)
      push_exp(a + k, hi4(brl[k], 0, 0, 0), 256);
    wait_idx(a + 7, 3000);
    @(posedge clk); #1;
    wr(0, 0, 1);
    for (int k = 8; k < 12; k++)
      push_exp(a + k, hi4(brl[k], 0, 0, 0), 256);
    wait_drain(3000);

    // reset in the middle of a full-duty period
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      wr(c, 1, 1);
      wr(c, 0, 255);
    end
    wait_idx(pidx + 1, 600);
    wait_idx(pidx + 1, 600);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("pre_rst_led", int'(led_out), 15);
    #2 rst = 1'b1;
    #1;
    check("rst_async_led", int'(led_out), 0);
    check("rst_async_ps", int'(period_start), 0);
    p = pidx;
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_ch   = 2'd0;
    wr_sel  = 1'b1;
    wr_data = 8'd1;
    @(posedge clk); #1;
    wr_sel  = 1'b0;
    wr_data = 8'd255;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("rst_hold_led", int'(led_out), 0);
    rst = 1'b0;
    for (int k = 1; k <= 2; k++)
      push_exp(p + k, hi4(0, 0, 0, 0), 256);
    n = 0;
    q = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (led_out != 4'd0) q++;
      if (period_start) break;
    end
    check("rst_quiet_led", q, 0);
    check("first_ps_cycles", n, 256);
    wait_drain(1200);

    // blink phase counts wraps from reset
    @(posedge clk); #1;
    wr(3, 1, 2);
    wr(3, 0, 255);
    for (int w = pidx + 1; w <= p + 34; w++) begin
      n = w - p;
      push_exp(w, hi4(0, 0, 0,
               (((n / 16) % 2) == 0) ? 255 : 0), 256);
    end
    wait_drain(34 * 256 + 1000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pwm_controller.md
LED_PWM_CONTROLLER -- requirements
Module: led_pwm_controller

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent LED channels (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8: PWM counter and duty width.
REQ-003 SHALL have parameter PRESC_BITS, default 8: prescaler width.
REQ-004 SHALL have parameter BLINK_PERIODS, default 16: PWM periods per blink phase (>=1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_en  input  1  register write strobe, one write per cycle.
REQ-008 SHALL have port wr_ch  input  $clog2(NUM_CH) (min 1)  target channel.
REQ-009 SHALL have port wr_sel  input  1  0 = duty register, 1 = mode register.
REQ-010 SHALL have port wr_data  input  PWM_BITS  write data; mode uses bits [1:0].
REQ-011 SHALL have port prescale  input  PRESC_BITS  tick divisor, tick every prescale+1 cycles.
REQ-012 SHALL have port led_out  output  NUM_CH  registered PWM outputs.
REQ-013 SHALL have port period_start  output  1  one-cycle pulse at each PWM period boundary.

Function
REQ-014 Prescaler SHALL count 0..prescale and assert internal tick in the cycle it equals prescale, then restart at 0; prescale=0 gives tick every cycle.
REQ-015 A prescale change SHALL take effect immediately; if the count exceeds the new value, the next cycle SHALL tick and restart at 0.
REQ-016 PWM counter SHALL increment on tick only, wrapping 2^PWM_BITS-1 -> 0.
REQ-017 period_start SHALL pulse high for exactly one cycle, in the cycle after the tick that wraps the PWM counter to 0.
REQ-018 Each channel SHALL hold shadow duty and mode registers written by wr_en with wr_ch/wr_sel; writes to wr_ch >= NUM_CH SHALL be ignored.
REQ-019 Shadow values SHALL copy into active registers only on the wrapping tick; a write in that same cycle SHALL be included in the copy.
REQ-020 Modes SHALL be: 00 OFF (level 0), 01 STATIC (level = duty), 10 BLINK (level = duty in phase ON, 0 in phase OFF), 11 BREATHE (ramped level).
REQ-021 Blink phase SHALL be shared across channels, starting ON, and toggle after every BLINK_PERIODS wrapping ticks.
REQ-022 BREATHE SHALL update once per wrapping tick: direction up and level < duty -> level+1; up and level >= duty -> direction down, level-1 (saturate at 0); down and level > 0 -> level-1; down and level = 0 -> direction up, level+1 (only if duty > 0).
REQ-023 Entering BREATHE from any other mode SHALL start at level 0, direction up.
REQ-024 Duty lowered below current BREATHE level SHALL force direction down.
REQ-025 led_out[i] SHALL be registered as (level_i > pwm_cnt), one cycle after the counter value; duty 0 -> never high; duty 2^PWM_BITS-1 -> high 2^PWM_BITS-1 of every 2^PWM_BITS ticks.

Reset
REQ-026 rst SHALL asynchronously clear prescaler, PWM counter, all shadow/active duty and mode (OFF), BREATHE levels (0, direction up), blink phase (ON) and blink counter.
REQ-027 During and after rst, led_out SHALL be 0 and period_start 0 until the first wrapping tick; reset mid-period SHALL abandon the period with no output glitch high.
REQ-028 Writes while rst is high SHALL be ignored.

Structure
REQ-029 Package led_pkg SHALL hold the 2-bit mode typedef (OFF/STATIC/BLINK/BREATHE) and default parameter constants.
REQ-030 Per-channel shadow/active registers, BREATHE ramp and compare SHALL live in sub-module led_channel, instantiated NUM_CH times; prescaler, PWM counter and blink phase stay in the top.

Verification
REQ-031 prescale=0, ch0 STATIC duty=64 -> led_out[0] high exactly 64 of every 256 cycles; period_start every 256 cycles.
REQ-032 prescale=3, ch1 STATIC duty=128 -> period 1024 cycles, led_out[1] high 512 cycles per period.
REQ-033 ch2 duty=100 -> 200 written mid-period -> current period stays 100, next period 200.
REQ-034 ch3 BLINK duty=255, BLINK_PERIODS=16 -> output active 16 periods, fully low 16 periods, repeating.
REQ-035 ch0 BREATHE duty=3 -> levels per period 1,2,3,2,1,0,1,2,... from entry.
REQ-036 rst asserted mid-period with all channels STATIC duty=255 -> led_out 0 same cycle, all mode registers read back OFF behaviour after release.
